// File: rtl/mul_lut_pipe_pkg.sv
// Shared constants and helpers for the multiply-then-lookup decode stage.
package mul_lut_pipe_pkg;

  // Odd parity of a 3-bit index: entry i is 1 when i has an odd number of ones.
  localparam logic [7:0] LUT_INIT_DEFAULT = 8'b1001_0110;

  function automatic logic [31:0] lut_index(input logic [63:0] prod,
                                            input int unsigned lsb,
                                            input int unsigned bits);
    logic [63:0] mask;
    mask = (64'd1 << bits) - 64'd1;
    return 32'((prod >> lsb) & mask);
  endfunction

endpackage

// File: rtl/mul_lut_pipe_lut_ram.sv
// 2^ADDR_W x 1 truth table: async reset to INIT, one sync write port, one comb read port.
module mul_lut_pipe_lut_ram #(
  parameter int unsigned                   ADDR_W = 3,
  parameter logic [(1 << ADDR_W)-1:0]      INIT   = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic              wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic              rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] mem;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= INIT;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mul_lut_pipe.sv
// Two-stage multiply, bit-field select and LUT decode with valid/ready and a saturating hit counter.
module mul_lut_pipe
  import mul_lut_pipe_pkg::*;
#(
  parameter int unsigned                  WIDTH    = 32,
  parameter int unsigned                  LUT_BITS = 3,
  parameter int unsigned                  LUT_LSB  = 0,
  parameter logic [(1 << LUT_BITS)-1:0]   LUT_INIT = LUT_INIT_DEFAULT,
  parameter int unsigned                  CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    signal_0,
  input  logic [WIDTH-1:0]    signal_1,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [WIDTH-1:0]    signal_A,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cfg_we,
  input  logic [LUT_BITS-1:0] cfg_addr,
  input  logic                cfg_data,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    hit_count
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic                adv;
  logic [WIDTH-1:0]    prod_p0;
  logic [WIDTH-1:0]    prod_p1;
  logic                vld_p1;
  logic [LUT_BITS-1:0] idx_p1;
  logic                lut_bit;

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage 0 -> 1: modulo-2^WIDTH product captured on accept
  assign prod_p0 = signal_0 * signal_1;

  always_ff @(posedge clk) begin
    if (adv && in_valid) begin
      prod_p1 <= prod_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage 1 -> 2: field select and table lookup into the output register
  assign idx_p1 = LUT_BITS'(lut_index(64'(prod_p1), LUT_LSB, LUT_BITS));

  mul_lut_pipe_lut_ram #(
    .ADDR_W (LUT_BITS),
    .INIT   (LUT_INIT)
  ) u_lut (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (cfg_we),
    .waddr (cfg_addr),
    .wdata (cfg_data),
    .raddr (idx_p1),
    .rdata (lut_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      signal_A  <= '0;
    end else if (adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        signal_A <= {{(WIDTH-1){1'b0}}, lut_bit};
      end
    end
  end

  // Output side: count transferred results equal to 1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count <= '0;
    end else if (cnt_clr) begin
      hit_count <= '0;
    end else if (out_valid && out_ready && signal_A[0]) begin
      hit_count <= sat_inc(hit_count);
    end
  end

endmodule

// File: tb/tb_mul_lut_pipe.sv
// Randomized and directed bench for mul_lut_pipe against a cycle-level behavioural model.
module tb_mul_lut_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] signal_0, signal_1;
  logic        in_valid, out_ready;
  logic        cfg_we, cfg_data, cnt_clr;
  logic [2:0]  cfg_addr;
  logic        in_ready, out_valid, in_ready_c, out_valid_c;
  logic [31:0] signal_A, signal_A_c;
  logic [15:0] hit_count;
  logic [1:0]  hit_count_c;

  always #5 clk = ~clk;

  mul_lut_pipe dut (
    .clk(clk), .rst_n(rst_n), .signal_0(signal_0), .signal_1(signal_1),
    .in_valid(in_valid), .in_ready(in_ready), .signal_A(signal_A),
    .out_valid(out_valid), .out_ready(out_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cnt_clr(cnt_clr),
    .hit_count(hit_count)
  );

  mul_lut_pipe #(.CNT_W(2)) dut_c (
    .clk(clk), .rst_n(rst_n), .signal_0(signal_0), .signal_1(signal_1),
    .in_valid(in_valid), .in_ready(in_ready_c), .signal_A(signal_A_c),
    .out_valid(out_valid_c), .out_ready(out_ready), .cfg_we(cfg_we),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cnt_clr(cnt_clr),
    .hit_count(hit_count_c)
  );

  // Behavioural model state
  bit          m_s1v, m_ov;
  logic [31:0] m_s1p, m_sa;
  bit   [7:0]  m_lut;
  int unsigned m_cnt, m_cntc;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_s1v = 0; m_ov = 0; m_sa = '0; m_s1p = '0;
    m_cnt = 0; m_cntc = 0;
    m_lut = 8'b1001_0110;
  endtask

  // Applies one rising edge using the values present just before it
  task automatic model_edge();
    bit              adv, xfer, hit;
    longint unsigned full;
    bit              n_ov;
    logic [31:0]     n_sa;
    adv  = !m_ov || out_ready;
    xfer = m_ov && out_ready;
    hit  = xfer && (m_sa % 2 == 1);
    n_ov = m_ov;
    n_sa = m_sa;
    if (adv) begin
      n_ov = m_s1v;
      if (m_s1v) n_sa = {31'd0, m_lut[m_s1p % 8]};
      m_s1v = in_valid;
      if (in_valid) begin
        full  = longint'(signal_0) * longint'(signal_1);
        m_s1p = full[31:0];
      end
    end
    m_ov = n_ov;
    m_sa = n_sa;
    if (cnt_clr) begin
      m_cnt = 0; m_cntc = 0;
    end else if (hit) begin
      if (m_cnt  < 65535) m_cnt++;
      if (m_cntc < 3)     m_cntc++;
    end
    if (cfg_we) m_lut[cfg_addr] = cfg_data;
  endtask

  task automatic check_all();
    chk("out_valid", 64'(out_valid), 64'(m_ov));
    chk("signal_A", 64'(signal_A), 64'(m_sa));
    chk("in_ready", 64'(in_ready), 64'(!m_ov || out_ready));
    chk("hit_count", 64'(hit_count), 64'(m_cnt));
    chk("hit_count_c", 64'(hit_count_c), 64'(m_cntc));
    chk("signal_A_c", 64'(signal_A_c), 64'(m_sa));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic put(input bit v, input logic [31:0] a, input logic [31:0] b);
    in_valid = v; signal_0 = a; signal_1 = b;
    cycle();
  endtask

  task automatic lut_write(input logic [2:0] addr, input bit d);
    cfg_we = 1; cfg_addr = addr; cfg_data = d;
    put(0, 0, 0);
    cfg_we = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; out_ready = 1; signal_0 = 0; signal_1 = 0;
    cfg_we = 0; cfg_addr = 0; cfg_data = 0; cnt_clr = 0;
    model_reset();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_signal_A", 64'(signal_A), 64'd0);
    chk("rst_hit", 64'(hit_count), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1;

    // 3*5 = 15 -> index 7 -> 1
    put(1, 3, 5);
    put(0, 0, 0);
    chk("t1_sa", 64'(signal_A), 64'd1);
    put(0, 0, 0);
    chk("t1_hit", 64'(hit_count), 64'd1);

    // Back-to-back: products 4,6,1,0 -> 1,0,1,0
    cnt_clr = 1; put(0, 0, 0); cnt_clr = 0;
    put(1, 2, 2); put(1, 3, 2); put(1, 1, 1); put(1, 0, 7);
    put(0, 0, 0); put(0, 0, 0); put(0, 0, 0);
    chk("t2_hit", 64'(hit_count), 64'd2);

    // Stall with 15 at the output and 4 in stage 1
    put(1, 3, 5); put(1, 2, 2);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      put(1, 1, 1);
      chk("t3_stall_ready", 64'(in_ready), 64'd0);
      chk("t3_stall_sa", 64'(signal_A), 64'd1);
    end
    out_ready = 1;
    put(0, 0, 0); put(0, 0, 0); put(0, 0, 0); put(0, 0, 0);

    // LUT write, then a write coinciding with the lookup of the same entry
    lut_write(7, 0);
    put(1, 3, 5); put(0, 0, 0);
    chk("t4_new", 64'(signal_A), 64'd0);
    lut_write(7, 1);
    put(1, 3, 5);
    cfg_we = 1; cfg_addr = 7; cfg_data = 0;
    put(0, 0, 0);
    cfg_we = 0;
    chk("t4_old", 64'(signal_A), 64'd1);
    lut_write(7, 1);

    // Saturation of the 2-bit counter, then clear against a hit
    cnt_clr = 1; put(0, 0, 0); cnt_clr = 0;
    for (int i = 0; i < 5; i++) put(1, 3, 5);
    put(0, 0, 0); put(0, 0, 0);
    chk("t5_sat", 64'(hit_count_c), 64'd3);
    chk("t5_full", 64'(hit_count), 64'd5);
    put(1, 3, 5); put(0, 0, 0);
    cnt_clr = 1; put(0, 0, 0); cnt_clr = 0;
    chk("t5_clr", 64'(hit_count), 64'd0);

    // Reset with two items in flight and a modified LUT
    lut_write(7, 0);
    put(1, 3, 5); put(1, 3, 5); put(1, 3, 5);
    #2 rst_n = 0;
    model_reset();
    #1;
    chk("t6_ov", 64'(out_valid), 64'd0);
    chk("t6_hit", 64'(hit_count), 64'd0);
    chk("t6_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #3;
    rst_n = 1;
    put(0, 0, 0); put(0, 0, 0); put(0, 0, 0);
    put(1, 3, 5); put(0, 0, 0);
    chk("t6_lut_init", 64'(signal_A), 64'd1);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 0) begin
        signal_0 = $urandom_range(0, 15);
        signal_1 = $urandom_range(0, 15);
      end else begin
        signal_0 = $urandom;
        signal_1 = $urandom;
      end
      cfg_we   = ($urandom_range(0, 19) == 0);
      cfg_addr = 3'($urandom_range(0, 7));
      cfg_data = 1'($urandom_range(0, 1));
      cnt_clr  = ($urandom_range(0, 49) == 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mul_lut_pipe.md
Name: mul_lut_pipe

Overview:
Pipelined, parametrised multiply-then-lookup block. It multiplies two operands, selects a configurable bit field of the product, and maps that field through a runtime-writable truth table to a 1-bit result, zero-extended onto signal_A. It adds valid/ready flow control, a loadable LUT, and a saturating hit counter. It serves as a reusable decode stage between arithmetic datapaths and downstream combinational-signal consumers.

Parameters:
WIDTH, 32, operand and output width in bits.
LUT_BITS, 3, width of the product field used as the LUT index; LUT has 2^LUT_BITS 1-bit entries.
LUT_LSB, 0, bit offset of the index field in the product; LUT_LSB+LUT_BITS <= WIDTH.
LUT_INIT, 8'b1001_0110, reset contents of the LUT, bit i = entry i. The default is odd parity of the index.
CNT_W, 16, hit counter width.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
signal_0  in  WIDTH  operand A
signal_1  in  WIDTH  operand B
in_valid  in  1  operands valid
in_ready  out  1  block can accept operands this cycle
signal_A  out  WIDTH  result, {WIDTH-1 zeros, lut_bit}
out_valid  out  1  signal_A valid
out_ready  in  1  downstream accepts signal_A
cfg_we  in  1  LUT write strobe
cfg_addr  in  LUT_BITS  LUT entry to write
cfg_data  in  1  value written
cnt_clr  in  1  synchronous clear of hit_count
hit_count  out  CNT_W  number of accepted results equal to 1, saturating

Behaviour:
- Reset (rst_n low, asynchronous): both stage valids = 0; out_valid = 0; signal_A = 0; hit_count = 0; LUT = LUT_INIT. Because in_ready is combinational, in_ready = 1 during reset.
- Global advance: adv = !out_valid || out_ready. in_ready = adv, combinational.
- Stage 1, on adv:
  - s1_valid <= in_valid.
  - If in_valid: s1_prod <= low WIDTH bits of signal_0*signal_1 (unsigned, modulo 2^WIDTH).
- Stage 2, on adv:
  - out_valid <= s1_valid.
  - If s1_valid: signal_A <= zero-extend(lut[s1_prod[LUT_LSB +: LUT_BITS]]).
- When adv = 0, all pipeline registers hold, including signal_A and out_valid.
- Latency: 2 cycles from accepted input to out_valid when no stall. Throughput: 1 per cycle.
- Bubbles: when in_valid = 0 on an advance, a bubble is inserted. signal_A holds its previous value whenever out_valid = 0 is loaded; it is not cleared.
- LUT write: on cfg_we, lut[cfg_addr] <= cfg_data at the clock edge. A lookup in that same edge uses the pre-write value; the new value applies from the next edge. cfg_we is honoured regardless of adv.
- Hit counter, evaluated each cycle on a transfer (out_valid && out_ready):
  - cnt_clr = 1: hit_count <= 0. Clear wins over a simultaneous increment.
  - Otherwise, if signal_A[0] == 1 and hit_count != all-ones: increment.
  - At all-ones, hit_count holds (saturates; no wrap).
- Reset mid-operation clears in-flight data; no partial result is emitted after rst_n rises.
- Holding out_ready = 0 with out_valid = 1 keeps signal_A stable until the transfer.

Decomposition:
- Shared package: default LUT_INIT constant (odd-parity table) and a function computing the LUT index from product, LUT_LSB and LUT_BITS.
- One sub-module, lut_ram: 2^LUT_BITS x 1 register array with async reset to LUT_INIT, one synchronous write port and one combinational read port.
- The multiplier and pipeline stay in the top block.

Test Plan:
1. Reset then signal_0=3, signal_1=5, in_valid pulse, out_ready=1 -> product 15, index 3'b111 -> two cycles later out_valid=1, signal_A=1, hit_count=1.
2. Back-to-back inputs (2,2), (3,2), (1,1), (0,7) -> consecutive outputs 1, 0, 1, 0 on cycles 2-5; hit_count=2.
3. out_ready=0 while out_valid=1 with 3*5 in flight and 2*2 arriving -> in_ready=0, signal_A holds 1 for the stall; on release, outputs 1 then 1 in order with none lost.
4. cfg_we addr=7 data=0, then 3*5 -> signal_A=0. The same write issued on the edge that looks up index 7 -> old value 1 is returned.
5. CNT_W=2, five hit transfers -> hit_count reads 1, 2, 3, 3, 3. cnt_clr coincident with a hit -> hit_count=0.
6. rst_n pulsed low with two valid items in flight -> out_valid=0 and hit_count=0 immediately; nothing emitted afterwards; LUT restored to LUT_INIT (address 7 reads 1 again).
